multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control FSM. Outputs are registered from the next-state decode.
// Define MULTICYCLE_JUMP_EN to include the JUMP state and the j opcode (000010).
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Reg_write_in,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       Branch,
    output logic       PCWrite,
    output logic       PCEn,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       branch;
        logic       pc_write;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:   n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_RTYPE:     n = EXECUTE;
                    OP_BEQ:       n = BRANCH;
                    OP_ADDI:      n = ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         n = JUMP;
`endif
                    default:      n = FETCH;
                endcase
            end
            MEMADR:  n = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   n = MEMWB;
            EXECUTE: n = ALUWB;
            ADDIEX:  n = ADDIWB;
            // Terminal states and any illegal code all return to FETCH.
            default: n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ADDIWB:  c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctrl  <= decode(FETCH);
        end else begin
            state <= next_state(state, Op);
            ctrl  <= decode(next_state(state, Op));
        end
    end

    // FETCH outputs are preloaded during reset; write enables stay masked until release.
    assign IorD         = ctrl.iord;
    assign MemWrite     = ctrl.mem_write & ~reset;
    assign IRWrite      = ctrl.ir_write  & ~reset;
    assign RegDst       = ctrl.reg_dst;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign Reg_write_in = ctrl.reg_write & ~reset;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign ALUOp        = ctrl.alu_op;
    assign PCSrc        = ctrl.pc_src;
    assign Branch       = ctrl.branch;
    assign PCWrite      = ctrl.pc_write & ~reset;
    assign PCEn         = (ctrl.pc_write | (ctrl.branch & Zero)) & ~reset;
    assign State        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; expected values are hand-derived per state.
module tb_multicycle_control;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, Reg_write_in, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       Branch, PCWrite, PCEn;
    logic [3:0] State;

    int n_checks = 0;
    int n_errors = 0;
    logic watch_mw = 1'b0;
    logic mw_seen  = 1'b0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .Reg_write_in(Reg_write_in),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .Branch(Branch), .PCWrite(PCWrite), .PCEn(PCEn), .State(State)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(MemWrite) if (watch_mw && MemWrite) mw_seen = 1'b1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_state(input string tag, input logic [3:0] exp);
        step();
        chk(tag, 8'(State), 8'(exp));
    endtask

    initial begin
        clk_en = 1'b0;
        reset  = 1'b1;
        Op     = 6'b100011;
        Zero   = 1'b0;
        #30;
        // Reset held with clock stopped.
        chk("rst_state",   8'(State), 8'd0);
        chk("rst_memwr",   8'(MemWrite), 8'd0);
        chk("rst_irwr",    8'(IRWrite), 8'd0);
        chk("rst_regwr",   8'(Reg_write_in), 8'd0);
        chk("rst_pcwr",    8'(PCWrite), 8'd0);
        chk("rst_pcen",    8'(PCEn), 8'd0);
        reset = 1'b0;
        #1;
        chk("rel_irwr",    8'(IRWrite), 8'd1);
        chk("rel_pcwr",    8'(PCWrite), 8'd1);
        chk("rel_srcb",    8'(ALUSrcB), 8'd1);
        clk_en = 1'b1;

        // lw: 0,1,2,3,4,0
        step_state("lw_s1", 4'd1);
        chk("lw_dec_srcb", 8'(ALUSrcB), 8'd3);
        chk("lw_dec_regwr", 8'(Reg_write_in), 8'd0);
        step_state("lw_s2", 4'd2);
        chk("lw_adr_srca", 8'(ALUSrcA), 8'd1);
        chk("lw_adr_srcb", 8'(ALUSrcB), 8'd2);
        step_state("lw_s3", 4'd3);
        chk("lw_rd_iord",  8'(IorD), 8'd1);
        chk("lw_rd_regwr", 8'(Reg_write_in), 8'd0);
        step_state("lw_s4", 4'd4);
        chk("lw_wb_regwr", 8'(Reg_write_in), 8'd1);
        chk("lw_wb_m2r",   8'(MemtoReg), 8'd1);
        step_state("lw_s0", 4'd0);
        chk("lw_f_regwr",  8'(Reg_write_in), 8'd0);
        chk("lw_f_m2r",    8'(MemtoReg), 8'd0);

        // beq taken
        Op = 6'b000100; Zero = 1'b1;
        step_state("beq1_s1", 4'd1);
        step_state("beq1_s8", 4'd8);
        chk("beq1_pcen",   8'(PCEn), 8'd1);
        chk("beq1_pcsrc",  8'(PCSrc), 8'd1);
        chk("beq1_aluop",  8'(ALUOp), 8'd1);
        chk("beq1_pcwr",   8'(PCWrite), 8'd0);
        step_state("beq1_s0", 4'd0);
        // beq not taken
        Zero = 1'b0;
        step_state("beq0_s1", 4'd1);
        step_state("beq0_s8", 4'd8);
        chk("beq0_pcen",   8'(PCEn), 8'd0);
        chk("beq0_branch", 8'(Branch), 8'd1);
        step_state("beq0_s0", 4'd0);

        // unsupported opcode: 0,1,0
        Op = 6'b111111;
        step_state("bad_s1", 4'd1);
        chk("bad_memwr",   8'(MemWrite), 8'd0);
        chk("bad_regwr",   8'(Reg_write_in), 8'd0);
        chk("bad_pcwr",    8'(PCWrite), 8'd0);
        step_state("bad_s0", 4'd0);

        // R-type: 0,1,6,7,0
        Op = 6'b000000;
        step_state("r_s1", 4'd1);
        step_state("r_s6", 4'd6);
        chk("r_ex_aluop",  8'(ALUOp), 8'd2);
        chk("r_ex_srca",   8'(ALUSrcA), 8'd1);
        step_state("r_s7", 4'd7);
        chk("r_wb_regdst", 8'(RegDst), 8'd1);
        chk("r_wb_regwr",  8'(Reg_write_in), 8'd1);
        step_state("r_s0", 4'd0);

        // addi: 0,1,9,10,0
        Op = 6'b001000;
        step_state("ai_s1", 4'd1);
        step_state("ai_s9", 4'd9);
        chk("ai_ex_srcb",  8'(ALUSrcB), 8'd2);
        step_state("ai_s10", 4'd10);
        chk("ai_wb_regwr", 8'(Reg_write_in), 8'd1);
        chk("ai_wb_regdst", 8'(RegDst), 8'd0);
        step_state("ai_s0", 4'd0);

        // sw full: 0,1,2,5,0
        Op = 6'b101011;
        step_state("sw_s1", 4'd1);
        step_state("sw_s2", 4'd2);
        step_state("sw_s5", 4'd5);
        chk("sw_memwr",    8'(MemWrite), 8'd1);
        chk("sw_iord",     8'(IorD), 8'd1);
        step_state("sw_s0", 4'd0);

        // sw aborted by reset in MEMADR
        watch_mw = 1'b1;
        step_state("swa_s1", 4'd1);
        step_state("swa_s2", 4'd2);
        reset = 1'b1;
        #1;
        chk("swa_rst_state", 8'(State), 8'd0);
        chk("swa_rst_memwr", 8'(MemWrite), 8'd0);
        #1;
        reset = 1'b0;
        Op = 6'b111111;
        step_state("swa_s1b", 4'd1);
        step_state("swa_s0b", 4'd0);
        watch_mw = 1'b0;
        chk("swa_memwr_seen", 8'(mw_seen), 8'd0);

        // jump
        Op = 6'b000010;
        step_state("j_s1", 4'd1);
`ifdef MULTICYCLE_JUMP_EN
        step_state("j_s11", 4'd11);
        chk("j_pcsrc",     8'(PCSrc), 8'd2);
        chk("j_pcen",      8'(PCEn), 8'd1);
        step_state("j_s0", 4'd0);
`else
        step_state("j_s0", 4'd0);
        chk("j_f_pcsrc",   8'(PCSrc), 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
